// File: rtl/ysyx_22050019_axi_dmem.sv
// ysyx_22050019_axi_dmem: AXI-lite slave data memory for the LSU.
// Single-ported 64-bit word array behind AR/R and AW/W/B with wait states.
module ysyx_22050019_axi_dmem #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axi_arvalid,
  input  logic [63:0] s_axi_araddr,
  output logic        s_axi_arready,
  output logic        s_axi_rvalid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  input  logic        s_axi_rready,
  input  logic        s_axi_awvalid,
  input  logic [63:0] s_axi_awaddr,
  output logic        s_axi_awready,
  input  logic        s_axi_wvalid,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  output logic        s_axi_wready,
  output logic        s_axi_bvalid,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_bready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [63:0] SPAN   = 64'(DEPTH) << 3;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  logic [63:0] mem [DEPTH];

  logic        idle;
  logic        wr_req;
  logic        ar_hs;
  logic        aw_hs;
  logic        done;
  logic        hit;
  logic        commit;
  logic [63:0] offset;
  logic [AW-1:0] idx;

  assign idle   = (state == IDLE);
  assign wr_req = s_axi_awvalid & s_axi_wvalid;

  // Ready outputs depend on state and AW/W valids only; writes win ties.
  assign s_axi_awready = rst_n & idle;
  assign s_axi_wready  = rst_n & idle;
  assign s_axi_arready = rst_n & idle & ~wr_req;

  assign aw_hs = wr_req & s_axi_awready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // One address register serves both directions; low 3 bits drop out.
  assign offset = addr_q - BASE;
  assign hit    = (addr_q >= BASE) && (offset < SPAN);
  assign idx    = offset[AW+2:3];
  assign done   = (cnt == 4'd0);
  assign commit = (state == WR_WAIT) && done && hit;

  // Transaction FSM: the counter is loaded with LATENCY-1 at the handshake,
  // so the response registers land LATENCY edges after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      wstrb_q      <= 8'd0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= 64'd0;
      s_axi_rresp  <= OKAY;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q  <= s_axi_awaddr;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
            cnt     <= LAT_M1;
            state   <= WR_WAIT;
          end else if (ar_hs) begin
            addr_q <= s_axi_araddr;
            cnt    <= LAT_M1;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (done) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= hit ? mem[idx] : 64'd0;
            s_axi_rresp  <= hit ? OKAY : DECERR;
            state        <= RD_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        WR_WAIT: begin
          if (done) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= hit ? OKAY : DECERR;
            state        <= WR_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane commit on the edge that raises bvalid; contents never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_dmem.sv
// tb_ysyx_22050019_axi_dmem: scoreboard bench for the AXI-lite dmem.
// Instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
module tb_ysyx_22050019_axi_dmem;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  logic        arvalid [2];
  logic        arready [2];
  logic [63:0] araddr  [2];
  logic        rvalid  [2];
  logic [63:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rready  [2];
  logic        awvalid [2];
  logic [63:0] awaddr  [2];
  logic        awready [2];
  logic        wvalid  [2];
  logic [63:0] wdata   [2];
  logic [7:0]  wstrb   [2];
  logic        wready  [2];
  logic        bvalid  [2];
  logic [1:0]  bresp   [2];
  logic        bready  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_22050019_axi_dmem #(
      .LATENCY((g == 0) ? 1 : 4)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axi_arvalid (arvalid[g]),
      .s_axi_araddr  (araddr[g]),
      .s_axi_arready (arready[g]),
      .s_axi_rvalid  (rvalid[g]),
      .s_axi_rdata   (rdata[g]),
      .s_axi_rresp   (rresp[g]),
      .s_axi_rready  (rready[g]),
      .s_axi_awvalid (awvalid[g]),
      .s_axi_awaddr  (awaddr[g]),
      .s_axi_awready (awready[g]),
      .s_axi_wvalid  (wvalid[g]),
      .s_axi_wdata   (wdata[g]),
      .s_axi_wstrb   (wstrb[g]),
      .s_axi_wready  (wready[g]),
      .s_axi_bvalid  (bvalid[g]),
      .s_axi_bresp   (bresp[g]),
      .s_axi_bready  (bready[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    bit          rd;
    logic [63:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rise_r [2];
  int   rise_b [2];
  logic pr_r   [2];
  logic pr_b   [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic push(int i, bit is_rd, logic [63:0] d, logic [1:0] r,
                      int due);
    exp_t e;
    e.inst = i;
    e.rd   = is_rd;
    e.data = d;
    e.resp = r;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Monitor: compares each response against the scoreboard head.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        pr_r[g] = 1'b0;
        pr_b[g] = 1'b0;
      end else begin
        if (rvalid[g]) begin
          if (!pr_r[g]) rise_r[g] = cyc;
          if (sb.size() == 0 || sb[0].inst != g || !sb[0].rd) begin
            chk("unexp_rvalid", 64'd1, 64'd0);
          end else if (!rready[g]) begin
            chk("r_stable", rdata[g], sb[0].data);
          end else begin
            chk("rdata", rdata[g], sb[0].data);
            chk("rresp", 64'(rresp[g]), 64'(sb[0].resp));
            chk("r_lat", 64'(rise_r[g]), 64'(sb[0].due));
            sb.delete(0);
          end
        end
        pr_r[g] = rvalid[g];
        if (bvalid[g]) begin
          if (!pr_b[g]) rise_b[g] = cyc;
          if (sb.size() == 0 || sb[0].inst != g || sb[0].rd) begin
            chk("unexp_bvalid", 64'd1, 64'd0);
          end else if (bready[g]) begin
            chk("bresp", 64'(bresp[g]), 64'(sb[0].resp));
            chk("b_lat", 64'(rise_b[g]), 64'(sb[0].due));
            sb.delete(0);
          end
        end
        pr_b[g] = bvalid[g];
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(int i, bit is_rd, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_rd ? arready[i] : (awready[i] && wready[i])) begin
        @(posedge clk);
        #1;
        t  = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk(is_rd ? "ar_timeout" : "aw_timeout", 64'd1, 64'd0);
  endtask

  task automatic rd(int i, logic [63:0] a, logic [63:0] d, logic [1:0] r,
                    int stall);
    int t;
    bit ok;
    int k;
    rready[i]  = (stall == 0);
    araddr[i]  = a;
    arvalid[i] = 1'b1;
    wait_hs(i, 1'b1, t, ok);
    arvalid[i] = 1'b0;
    if (ok) begin
      push(i, 1'b1, d, r, t + lat(i));
      if (stall > 0) begin
        k = 0;
        while (!rvalid[i] && k < 20) begin
          @(negedge clk);
          k++;
        end
        chk("stall_rvalid", 64'(rvalid[i]), 64'd1);
        repeat (stall) begin
          @(negedge clk);
          chk("ar_blocked", 64'(arready[i]), 64'd0);
        end
        @(posedge clk);
        #1;
      end
    end
    rready[i] = 1'b1;
    drain();
  endtask

  task automatic wr(int i, logic [63:0] a, logic [63:0] d, logic [7:0] s,
                    logic [1:0] r);
    int t;
    bit ok;
    bready[i]  = 1'b1;
    awaddr[i]  = a;
    wdata[i]   = d;
    wstrb[i]   = s;
    awvalid[i] = 1'b1;
    wvalid[i]  = 1'b1;
    wait_hs(i, 1'b0, t, ok);
    awvalid[i] = 1'b0;
    wvalid[i]  = 1'b0;
    if (ok) push(i, 1'b0, 64'd0, r, t + lat(i));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int tr;
    bit ok;
    for (int g = 0; g < 2; g++) begin
      arvalid[g] = 1'b1;
      awvalid[g] = 1'b1;
      wvalid[g]  = 1'b1;
      rready[g]  = 1'b1;
      bready[g]  = 1'b1;
      araddr[g]  = 64'd0;
      awaddr[g]  = 64'd0;
      wdata[g]   = 64'd0;
      wstrb[g]   = 8'd0;
      rise_r[g]  = 0;
      rise_b[g]  = 0;
      pr_r[g]    = 1'b0;
      pr_b[g]    = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_rdata", rdata[g], 64'd0);
      chk("rst_ctl", 64'({rvalid[g], bvalid[g], rresp[g], bresp[g],
                          arready[g], awready[g], wready[g]}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("idle_ready", 64'({arready[g], awready[g], wready[g]}),
          64'(3'b011));
      arvalid[g] = 1'b0;
      awvalid[g] = 1'b0;
      wvalid[g]  = 1'b0;
    end
    @(posedge clk);
    #1;

    wr(0, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 2'b00);
    rd(0, 64'h8000_0010, 64'h1122334455667788, 2'b00, 0);
    wr(0, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 2'b00);
    rd(0, 64'h8000_0010, 64'h11223344BBBBBBBB, 2'b00, 0);
    rd(0, 64'h8000_0014, 64'h11223344BBBBBBBB, 2'b00, 0);
    wr(0, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00);
    rd(0, 64'h8000_0010, 64'h11223344BBBBBBBB, 2'b00, 0);
    wr(0, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 2'b00);
    wr(0, 64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF, 2'b11);
    rd(0, 64'h8000_0000, 64'h0123456789ABCDEF, 2'b00, 0);
    rd(0, 64'h7FFF_FFF8, 64'd0, 2'b11, 0);
    rd(0, 64'h8000_8000, 64'd0, 2'b11, 0);
    wr(0, 64'h8000_7FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 2'b00);
    rd(0, 64'h8000_7FF8, 64'hCAFE_F00D_1234_5678, 2'b00, 0);

    arvalid[0] = 1'b1;
    araddr[0]  = 64'h8000_0020;
    awvalid[0] = 1'b1;
    wvalid[0]  = 1'b1;
    awaddr[0]  = 64'h8000_0020;
    wdata[0]   = 64'h0F0E0D0C0B0A0908;
    wstrb[0]   = 8'hFF;
    @(negedge clk);
    chk("sim_arready", 64'(arready[0]), 64'd0);
    chk("sim_awready", 64'(awready[0]), 64'd1);
    @(posedge clk);
    #1;
    t = cyc;
    push(0, 1'b0, 64'd0, 2'b00, t + 1);
    awvalid[0] = 1'b0;
    wvalid[0]  = 1'b0;
    ok = 1'b0;
    tr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (arready[0]) begin
        @(posedge clk);
        #1;
        tr = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    arvalid[0] = 1'b0;
    chk("sim_rd_edge", 64'(tr), 64'(t + 3));
    if (ok) push(0, 1'b1, 64'h0F0E0D0C0B0A0908, 2'b00, tr + 1);
    drain();

    wr(1, 64'h8000_0100, 64'hDEADBEEF01234567, 8'hFF, 2'b00);
    rd(1, 64'h8000_0100, 64'hDEADBEEF01234567, 2'b00, 3);

    rready[1]  = 1'b1;
    araddr[1]  = 64'h8000_0100;
    arvalid[1] = 1'b1;
    wait_hs(1, 1'b1, t, ok);
    arvalid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(rvalid[1]), 64'd0);
    chk("rst_mid_ready", 64'({arready[1], awready[1], wready[1]}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rvalid", 64'(rvalid[1]), 64'd0);
    end
    @(posedge clk);
    #1;

    bready[1]  = 1'b1;
    awaddr[1]  = 64'h8000_0100;
    wdata[1]   = 64'd0;
    wstrb[1]   = 8'hFF;
    awvalid[1] = 1'b1;
    wvalid[1]  = 1'b1;
    wait_hs(1, 1'b0, t, ok);
    awvalid[1] = 1'b0;
    wvalid[1]  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_bvalid", 64'(bvalid[1]), 64'd0);
    end
    @(posedge clk);
    #1;
    rd(1, 64'h8000_0100, 64'hDEADBEEF01234567, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
